// File: rtl/ldm_addr_gen_pkg.sv
// Shared types and helpers for the LDM/STM address generator.
package ldm_addr_gen_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StXfer,
    StWb
  } state_e;

  localparam int unsigned WORD_BYTES = 4;

  function automatic logic [4:0] popcount16(input logic [15:0] vec);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + {4'b0000, vec[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/ldm_popcount.sv
// Combinational 16-bit population count.
module ldm_popcount
  import ldm_addr_gen_pkg::*;
(
  input  logic [15:0] vec_i,
  output logic [4:0]  cnt_o
);

  assign cnt_o = popcount16(vec_i);

endmodule

// File: rtl/ldm_addr_gen.sv
// Turns LDM/STM sequencer strobes into registered data-bus requests and a base writeback.
// Optional unaligned-base flag is built only when LDM_ADDR_ALIGN_CHK_EN is defined.
module ldm_addr_gen
  import ldm_addr_gen_pkg::*;
#(
  parameter int unsigned AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          i_start,
  input  logic [AW-1:0] i_base,
  input  logic [3:0]    i_rn,
  input  logic [15:0]   i_reglist,
  input  logic          i_u,
  input  logic          i_w,
  input  logic          i_l,
  input  logic          i_mem_vld,
  input  logic [AW-1:0] i_offset,
  input  logic [3:0]    i_reg_code,
  input  logic          i_dmem_ready,
  output logic          o_dmem_req,
  output logic          o_dmem_we,
  output logic [AW-1:0] o_dmem_addr,
  output logic [3:0]    o_dmem_reg,
  output logic          o_stall,
  output logic          o_busy,
  output logic          o_wb_vld,
  output logic [3:0]    o_wb_reg,
  output logic [AW-1:0] o_wb_data,
  output logic          o_align_fault
);

  state_e        state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [3:0]    rn_q, rn_d;
  logic          u_q, u_d, w_q, w_d, l_q, l_d, bil_q, bil_d;
  logic [4:0]    n_q, n_d, cnt_q, cnt_d;
  logic          req_q, req_d, we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    reg_q, reg_d;

  logic [4:0]    list_cnt;
  logic          start_ok, capture, accept, last;
  logic [AW-1:0] xfer_sum, wb_span, wb_val;

  ldm_popcount u_popcount (
    .vec_i (i_reglist),
    .cnt_o (list_cnt)
  );

  assign start_ok = en & i_start & (list_cnt != 5'd0) & (state_q == StIdle);
  assign o_stall  = req_q & ~i_dmem_ready;
  assign capture  = en & i_mem_vld & ~o_stall & (state_q == StXfer);
  assign accept   = req_q & i_dmem_ready;
  assign last     = accept & ((cnt_q + 5'd1) == n_q);
  assign xfer_sum = u_q ? base_q + i_offset : base_q - i_offset;
  assign wb_span  = AW'(n_q) * AW'(WORD_BYTES);
  assign wb_val   = u_q ? base_q + wb_span : base_q - wb_span;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    rn_d    = rn_q;
    u_d     = u_q;
    w_d     = w_q;
    l_d     = l_q;
    bil_d   = bil_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    reg_d   = reg_q;
    case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d = StXfer;
          base_d  = {i_base[AW-1:2], 2'b00};
          rn_d    = i_rn;
          u_d     = i_u;
          w_d     = i_w;
          l_d     = i_l;
          bil_d   = i_reglist[i_rn];
          n_d     = list_cnt;
          cnt_d   = '0;
        end
      end
      StXfer: begin
        if (capture) begin
          req_d  = 1'b1;
          we_d   = ~l_q;
          addr_d = {xfer_sum[AW-1:2], 2'b00};
          reg_d  = i_reg_code;
        end else if (accept) begin
          req_d = 1'b0;
        end
        if (accept) begin
          cnt_d = cnt_q + 5'd1;
        end
        // Final acceptance wins over any stray capture in the same cycle.
        if (last) begin
          req_d   = 1'b0;
          state_d = StWb;
        end
      end
      StWb: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      base_q  <= '0;
      rn_q    <= '0;
      u_q     <= 1'b0;
      w_q     <= 1'b0;
      l_q     <= 1'b0;
      bil_q   <= 1'b0;
      n_q     <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      reg_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      rn_q    <= rn_d;
      u_q     <= u_d;
      w_q     <= w_d;
      l_q     <= l_d;
      bil_q   <= bil_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      reg_q   <= reg_d;
    end
  end

  assign o_dmem_req  = req_q;
  assign o_dmem_we   = we_q;
  assign o_dmem_addr = addr_q;
  assign o_dmem_reg  = reg_q;
  assign o_busy      = (state_q != StIdle);
  // A loaded base register wins over the writeback.
  assign o_wb_vld    = (state_q == StWb) & w_q & ~(l_q & bil_q);
  assign o_wb_reg    = (state_q == StWb) ? rn_q : 4'd0;
  assign o_wb_data   = (state_q == StWb) ? wb_val : '0;

`ifdef LDM_ADDR_ALIGN_CHK_EN
  logic align_q, align_d;

  always_comb begin
    align_d = align_q;
    if (start_ok) begin
      align_d = |i_base[1:0];
    end else if (state_q == StWb) begin
      align_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      align_q <= 1'b0;
    end else begin
      align_q <= align_d;
    end
  end

  assign o_align_fault = align_q;
`else
  logic unused_base_lo;
  assign unused_base_lo = ^i_base[1:0];
  assign o_align_fault  = 1'b0;
`endif

endmodule
